// File: rtl/ofdm_pkg.sv
// Shared constants and types for the OFDM transmit path: sample width, frame size,
// FFT-sink framing FSM encoding and Avalon-ST error codes.
package ofdm_pkg;
    localparam int DATA_W     = 8;
    localparam int FRAME_LEN  = 16;
    localparam int FIFO_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_STARVE = 2'd2
    } frm_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered output stage; the head entry is
// presented one edge after it was written and holds while not popped.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   rd_i,
    output logic [W-1:0]           rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic [W-1:0]  dout_q;
    logic          wr_ok, rd_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign rd_ok   = rd_i && vld_q;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
    assign wr_ok   = wr_i && (!full_o || rd_ok);
    assign rptr_d  = rptr_q + AW'(rd_ok);
    assign cnt_d   = cnt_q + CW'(wr_ok) - CW'(rd_ok);
    // Entries written this very edge are not yet readable, so they don't count here.
    assign vld_d   = (cnt_q - CW'(rd_ok)) != '0;

    assign rdata_o = dout_q;
    assign empty_o = !vld_q;
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            dout_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_ok) mem_q[wptr_q] <= wdata_i;
            wptr_q <= wptr_q + AW'(wr_ok);
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            dout_q <= mem_q[rptr_d];
        end
    end
endmodule

// File: rtl/fft_sink_framer.sv
// Buffers Sorter re/im sample pairs and frames them onto the FFT core's Avalon-ST
// sink as FRAME_LEN-sample IFFT frames with sop/eop, sticky overflow reporting.
module fft_sink_framer #(
    parameter int DATA_W     = ofdm_pkg::DATA_W,
    parameter int FRAME_LEN  = ofdm_pkg::FRAME_LEN,
    parameter int FIFO_DEPTH = ofdm_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              sink_ready,
    output logic              sink_valid,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    output logic [DATA_W-1:0] sink_imag,
    output logic [1:0]        sink_error,
    output logic              inverse,
    output logic              overflow
);
    import ofdm_pkg::frm_state_e, ofdm_pkg::ST_IDLE, ofdm_pkg::ST_SEND, ofdm_pkg::ST_STARVE;
    import ofdm_pkg::ERR_NONE, ofdm_pkg::ERR_OVF;

    localparam int IW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

    logic                fifo_empty, fifo_full;
    logic [CW-1:0]       fifo_cnt;
    logic [2*DATA_W-1:0] fifo_dout;
    logic                xfer, wr_ok, drop, last, emptying;
    frm_state_e          state_q;
    logic [IW-1:0]       idx_q, idx_d;
    logic                ovf_q, ovf_d;

    sync_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .wr_i    (in_valid),
        .wdata_i ({in_re, in_im}),
        .rd_i    (sink_ready),
        .rdata_o (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    assign sink_valid = !fifo_empty;
    assign xfer       = sink_valid && sink_ready;
    assign wr_ok      = in_valid && (!fifo_full || xfer);
    assign drop       = in_valid && !wr_ok;
    assign last       = (idx_q == IDX_LAST);
    assign emptying   = xfer && !wr_ok && (fifo_cnt == CW'(1));

    assign idx_d = xfer ? (last ? '0 : idx_q + IW'(1)) : idx_q;
    assign ovf_d = ovf_q || drop;

    assign sink_sop   = sink_valid && (idx_q == '0);
    assign sink_eop   = sink_valid && last;
    assign sink_real  = fifo_dout[2*DATA_W-1:DATA_W];
    assign sink_imag  = fifo_dout[DATA_W-1:0];
    assign sink_error = ovf_q ? ERR_OVF : ERR_NONE;
    assign inverse    = 1'b1;
    assign overflow   = ovf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            ovf_q <= ovf_d;
        end
    end

    // Frame-level view of the stream; a starved frame keeps its index and resumes without sop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (wr_ok) state_q <= ST_SEND;
                ST_SEND:   if (emptying) state_q <= last ? ST_IDLE : ST_STARVE;
                ST_STARVE: if (wr_ok) state_q <= ST_SEND;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_sink_framer.sv
// Scoreboard bench for fft_sink_framer: expected samples (with sop/eop by stream
// position) are queued at write time and checked on every sink transfer.
module tb_fft_sink_framer;
    localparam int DW = 8;
    localparam int FL = 16;
    localparam int FD = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          sink_ready = 1'b0;
    logic          sink_valid, sink_sop, sink_eop, inverse, overflow;
    logic [DW-1:0] sink_real, sink_imag;
    logic [1:0]    sink_error;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_assert = 0, n_fail = 0;
    int            n_xfer = 0, n_sop = 0, n_eop = 0;
    int            exp_k = 0, cyc_cnt = 0, first_vld = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_re = '0, prev_im = '0;

    fft_sink_framer #(.DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .sink_ready (sink_ready),
        .sink_valid (sink_valid),
        .sink_sop   (sink_sop),
        .sink_eop   (sink_eop),
        .sink_real  (sink_real),
        .sink_imag  (sink_imag),
        .sink_error (sink_error),
        .inverse    (inverse),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    // Monitor: samples at the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (sink_valid && first_vld < 0) first_vld = cyc_cnt;
            if (prev_stall) begin
                n_assert++;
                if (sink_valid !== 1'b1 || sink_real !== prev_re || sink_imag !== prev_im) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b re=%0d im=%0d, need v=1 re=%0d im=%0d",
                             sink_valid, sink_real, sink_imag, prev_re, prev_im);
                end
            end
            if (sink_valid && sink_ready) begin
                n_xfer++;
                if (sink_sop) n_sop++;
                if (sink_eop) n_eop++;
                n_assert++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got re=%0d im=%0d sop=%0b eop=%0b, need no transfer",
                             sink_real, sink_imag, sink_sop, sink_eop);
                end else begin
                    mon_e = sb.pop_front();
                    if ({sink_real, sink_imag, sink_sop, sink_eop} !== {mon_e.re, mon_e.im, mon_e.sop, mon_e.eop}) begin
                        n_fail++;
                        $display("FAIL sb_data: got re=%0d im=%0d sop=%0b eop=%0b, need re=%0d im=%0d sop=%0b eop=%0b",
                                 sink_real, sink_imag, sink_sop, sink_eop, mon_e.re, mon_e.im, mon_e.sop, mon_e.eop);
                    end
                end
            end
            prev_stall = sink_valid && !sink_ready;
            prev_re    = sink_real;
            prev_im    = sink_imag;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit keep);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        if (keep) begin
            sb.push_back('{re, im, (exp_k % FL) == 0, (exp_k % FL) == FL - 1});
            exp_k++;
        end
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        n_assert++;
        if ({sink_valid, sink_sop, sink_eop} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_ctrl: got v/sop/eop=%b, need 000", {sink_valid, sink_sop, sink_eop});
        end
        n_assert++;
        if ({sink_real, sink_imag} !== '0) begin
            n_fail++;
            $display("FAIL rst_data: got re=%0d im=%0d, need 0 0", sink_real, sink_imag);
        end
        n_assert++;
        if ({inverse, overflow, sink_error} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_status: got inv=%0b ovf=%0b err=%b, need 1 0 00", inverse, overflow, sink_error);
        end
        reset_n = 1'b1;
        repeat (2) cyc();
        n_assert++;
        if ({sink_valid, sink_real, sink_imag, inverse} !== {1'b0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_rst: got v=%0b re=%0d im=%0d inv=%0b, need 0 0 0 1",
                     sink_valid, sink_real, sink_imag, inverse);
        end
    endtask

    task automatic test_basic();
        int wr_edge, x0, s0, e0;
        bit ok;
        x0 = n_xfer; s0 = n_sop; e0 = n_eop;
        first_vld  = -1;
        sink_ready = 1'b1;
        put(8'd0, 8'd15, 1'b1);
        wr_edge = cyc_cnt;
        for (int i = 1; i < 16; i++) put(8'(i), 8'(15 - i), 1'b1);
        wait_drain(40, ok);
        n_assert++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_drain: got %0d left, need 0", sb.size()); end
        n_assert++;
        if (first_vld !== wr_edge + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got first valid at edge %0d, need %0d", first_vld, wr_edge + 1);
        end
        n_assert++;
        if ({n_xfer - x0, n_sop - s0, n_eop - e0} !== {32'd16, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL basic_counts: got xfer=%0d sop=%0d eop=%0d, need 16 1 1", n_xfer - x0, n_sop - s0, n_eop - e0);
        end
    endtask

    task automatic test_overflow();
        int s0, e0;
        bit ok;
        s0 = n_sop; e0 = n_eop;
        sink_ready = 1'b0;
        for (int i = 0; i < 32; i++) put(8'(i * 3 + 1), 8'(200 - i), 1'b1);
        n_assert++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %0b, need 0", overflow); end
        put(8'hEE, 8'hEE, 1'b0);
        n_assert++;
        if ({overflow, sink_error} !== 3'b101) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%0b err=%b, need 1 01", overflow, sink_error);
        end
        sink_ready = 1'b1;
        wait_drain(60, ok);
        n_assert++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_drain: got %0d left, need 0", sb.size()); end
        repeat (2) cyc();
        n_assert++;
        if (sink_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_extra: got valid=%0b, need 0", sink_valid); end
        n_assert++;
        if ({n_sop - s0, n_eop - e0} !== {32'd2, 32'd2}) begin
            n_fail++;
            $display("FAIL ovf_frames: got sop=%0d eop=%0d, need 2 2", n_sop - s0, n_eop - e0);
        end
        n_assert++;
        if ({overflow, sink_error} !== 3'b101) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%0b err=%b, need 1 01", overflow, sink_error);
        end
    endtask

    task automatic test_reset_midframe();
        int x0, s0, e0, t;
        bit ok;
        x0 = n_xfer;
        sink_ready = 1'b0;
        for (int i = 0; i < 10; i++) put(8'(50 + i), 8'(60 + i), 1'b1);
        sink_ready = 1'b1;
        t = 0;
        while (n_xfer - x0 < 7 && t < 40) begin
            @(posedge clk);
            t++;
        end
        n_assert++;
        if (n_xfer - x0 !== 7) begin n_fail++; $display("FAIL mid_xfers: got %0d, need 7", n_xfer - x0); end
        #3;
        reset_n    = 1'b0;
        sink_ready = 1'b0;
        sb.delete();
        exp_k = 0;
        #1;
        n_assert++;
        if ({sink_valid, sink_sop, sink_eop, sink_real, sink_imag, overflow, sink_error, inverse} !== {3'b000, 16'h0, 3'b000, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_rst: got v=%0b re=%0d im=%0d ovf=%0b err=%b inv=%0b, need 0 0 0 0 00 1",
                     sink_valid, sink_real, sink_imag, overflow, sink_error, inverse);
        end
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        s0 = n_sop; e0 = n_eop;
        sink_ready = 1'b1;
        for (int i = 0; i < 16; i++) put(8'(128 + i), 8'(i * 5), 1'b1);
        wait_drain(40, ok);
        n_assert++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_drain: got %0d left, need 0", sb.size()); end
        n_assert++;
        if ({n_sop - s0, n_eop - e0, 31'(0), overflow} !== {32'd1, 32'd1, 31'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL mid_after: got sop=%0d eop=%0d ovf=%0b, need 1 1 0", n_sop - s0, n_eop - e0, overflow);
        end
    endtask

    task automatic test_starve();
        int s0, e0;
        bit ok;
        s0 = n_sop; e0 = n_eop;
        sink_ready = 1'b1;
        for (int i = 0; i < 5; i++) put(8'(70 + i), 8'(90 - i), 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i >= 3) begin
                n_assert++;
                if (sink_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL starve_gap: got valid=%0b at gap cycle %0d, need 0", sink_valid, i);
                end
            end
            cyc();
        end
        for (int i = 5; i < 16; i++) put(8'(70 + i), 8'(90 - i), 1'b1);
        wait_drain(40, ok);
        n_assert++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL starve_drain: got %0d left, need 0", sb.size()); end
        n_assert++;
        if ({n_sop - s0, n_eop - e0} !== {32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL starve_frames: got sop=%0d eop=%0d, need 1 1", n_sop - s0, n_eop - e0);
        end
    endtask

    task automatic test_toggle();
        int x0;
        x0 = n_xfer;
        for (int i = 0; i < 32; i++) begin
            sink_ready = i[0];
            put(8'(i + 160), 8'(i ^ 8'h5A), 1'b1);
        end
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            sink_ready = ~sink_ready;
            cyc();
        end
        repeat (2) cyc();
        n_assert++;
        if ({n_xfer - x0, sb.size()} !== {32'd32, 32'd0}) begin
            n_fail++;
            $display("FAIL toggle_count: got xfer=%0d left=%0d, need 32 0", n_xfer - x0, sb.size());
        end
        n_assert++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL toggle_ovf: got %0b, need 0", overflow); end
    endtask

    task automatic test_full_simul();
        int x0;
        bit ok;
        x0 = n_xfer;
        sink_ready = 1'b0;
        for (int i = 0; i < 32; i++) put(8'(i + 1), 8'(i + 33), 1'b1);
        sink_ready = 1'b1;
        put(8'hAB, 8'hCD, 1'b1);
        sink_ready = 1'b0;
        cyc();
        n_assert++;
        if ({overflow, sink_error} !== 3'b000) begin
            n_fail++;
            $display("FAIL full_simul_ovf: got ovf=%0b err=%b, need 0 00", overflow, sink_error);
        end
        sink_ready = 1'b1;
        wait_drain(60, ok);
        n_assert++;
        if ({ok, n_xfer - x0} !== {1'b1, 32'd33}) begin
            n_fail++;
            $display("FAIL full_simul_count: got ok=%0b xfer=%0d, need 1 33", ok, n_xfer - x0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_reset_midframe();
        test_starve();
        test_toggle();
        test_full_simul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
